// File: rtl/snoop_bus_ctrl_pkg.sv
// Types and helpers private to the snoop bus sequencer.
package snoop_bus_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GRANT = 3'd1,
      ST_SNOOP = 3'd2,
      ST_MEM   = 3'd3,
      ST_DONE  = 3'd4
   } bus_state_t;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/system_widths_pkg.sv
// Widths and bus operation codes shared by the coherence bus, caches and MIU.
package system_widths_pkg;

   localparam int ADDR_W = 32;

   typedef enum logic [1:0] {
      BUS_RD   = 2'd0,
      BUS_RDX  = 2'd1,
      BUS_UPGR = 2'd2,
      BUS_WB   = 2'd3
   } bus_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: lowest requesting index at or above ptr_i, wrapping around.
module rr_arbiter #(
   parameter int N     = 3,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   always_comb begin
      logic found;
      int   j;
      found = 1'b0;
      j     = 0;
      idx_o = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N) j = j - N;
         if (!found && req_i[j]) begin
            found = 1'b1;
            idx_o = IDX_W'(j);
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Coherence bus sequencer: arbitrate, broadcast snoop, collect responses,
// optionally access memory, then pulse done to the winner.
module snoop_bus_ctrl
   import system_widths_pkg::bus_op_t, system_widths_pkg::BUS_RD,
          system_widths_pkg::BUS_UPGR, system_widths_pkg::BUS_WB;
   import snoop_bus_ctrl_pkg::*;
#(
   parameter int N      = 3,
   parameter int ADDR_W = system_widths_pkg::ADDR_W
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic [N-1:0]          req_i,
   input  logic [2*N-1:0]        req_op_i,
   input  logic [N*ADDR_W-1:0]   req_addr_i,
   output logic [N-1:0]          gnt_o,
   output logic [N-1:0]          done_o,
   output logic                  shared_o,
   output logic                  snp_valid_o,
   output logic [1:0]            snp_op_o,
   output logic [ADDR_W-1:0]     snp_addr_o,
   output logic [$clog2(N)-1:0]  snp_src_o,
   input  logic [N-1:0]          snp_ack_i,
   input  logic [N-1:0]          snp_hit_i,
   input  logic [N-1:0]          snp_dirty_i,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   input  logic                  mem_ready_i,
   output logic                  busy_o
);

   localparam int SRC_W = $clog2(N);

   bus_state_t        state_q, state_d;
   logic [SRC_W-1:0]  win_q, win_d, rr_ptr_q, rr_ptr_d;
   bus_op_t           op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [N-1:0]      ack_q, ack_d, hit_q, hit_d, dirty_q, dirty_d;
   logic              mem_we_q, mem_we_d;

   logic [N-1:0]      arb_req, win_oh, ack_all, hit_acc, dirty_acc;
   logic              arb_valid;
   logic [SRC_W-1:0]  arb_idx;
   bus_op_t           sel_op;
   logic [ADDR_W-1:0] sel_addr;

   assign arb_req = (state_q == ST_IDLE) ? req_i : '0;

   rr_arbiter #(.N(N), .IDX_W(SRC_W)) u_arb (
      .req_i   (arb_req),
      .ptr_i   (rr_ptr_q),
      .valid_o (arb_valid),
      .idx_o   (arb_idx)
   );

   always_comb begin
      win_oh   = '0;
      sel_op   = BUS_RD;
      sel_addr = '0;
      for (int i = 0; i < N; i++) begin
         if (win_q == SRC_W'(i)) win_oh[i] = 1'b1;
         if (arb_idx == SRC_W'(i)) begin
            sel_op   = bus_op_t'(req_op_i[2*i +: 2]);
            sel_addr = req_addr_i[ADDR_W*i +: ADDR_W];
         end
      end
   end

   // The source never answers its own snoop: its bit counts as acked, its hit/dirty are dropped.
   assign ack_all   = ack_q | (snp_ack_i & ~win_oh) | win_oh;
   assign hit_acc   = hit_q | (snp_hit_i & snp_ack_i & ~win_oh);
   assign dirty_acc = dirty_q | (snp_dirty_i & snp_ack_i & ~win_oh);

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q  <= ST_IDLE;
         win_q    <= '0;
         rr_ptr_q <= '0;
         op_q     <= BUS_RD;
         addr_q   <= '0;
         ack_q    <= '0;
         hit_q    <= '0;
         dirty_q  <= '0;
         mem_we_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         rr_ptr_q <= rr_ptr_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         ack_q    <= ack_d;
         hit_q    <= hit_d;
         dirty_q  <= dirty_d;
         mem_we_q <= mem_we_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      rr_ptr_d = rr_ptr_q;
      op_d     = op_q;
      addr_d   = addr_q;
      ack_d    = ack_q;
      hit_d    = hit_q;
      dirty_d  = dirty_q;
      mem_we_d = mem_we_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               win_d   = arb_idx;
               op_d    = sel_op;
               addr_d  = sel_addr;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            ack_d   = '0;
            hit_d   = '0;
            dirty_d = '0;
            if (op_q == BUS_WB) begin
               mem_we_d = 1'b1;
               state_d  = ST_MEM;
            end else begin
               state_d  = ST_SNOOP;
            end
         end
         ST_SNOOP: begin
            ack_d   = ack_all;
            hit_d   = hit_acc;
            dirty_d = dirty_acc;
            if (&ack_all) begin
               if (op_q == BUS_UPGR) begin
                  state_d = ST_DONE;
               end else begin
                  mem_we_d = |dirty_acc;
                  state_d  = ST_MEM;
               end
            end
         end
         ST_MEM: begin
            if (mem_ready_i) state_d = ST_DONE;
         end
         ST_DONE: begin
            rr_ptr_d = SRC_W'(wrap_inc(int'(win_q), N));
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o      = (state_q != ST_IDLE);
      gnt_o       = busy_o ? win_oh : '0;
      done_o      = (state_q == ST_DONE) ? win_oh : '0;
      shared_o    = (state_q == ST_DONE) && (op_q != BUS_WB) && (|hit_q);
      snp_valid_o = (state_q == ST_SNOOP);
      snp_op_o    = snp_valid_o ? op_q : 2'b00;
      snp_addr_o  = snp_valid_o ? addr_q : '0;
      snp_src_o   = snp_valid_o ? win_q : '0;
      mem_req_o   = (state_q == ST_MEM);
      mem_we_o    = mem_req_o & mem_we_q;
      mem_addr_o  = mem_req_o ? addr_q : '0;
   end

endmodule
